// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, 4-bit ALU control codes, datapath width.
// Shared with the EX-stage ALU so that the control-code table is defined in one place only.
package alu_pkg;
   localparam int XLEN = 32;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   // alt selects SUB on funct3 000 and SRA on funct3 101; the caller qualifies it per opcode.
   function automatic logic [3:0] f3_ctrl(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  f3_ctrl = alt ? ALU_SUB : ALU_ADD;
         3'b001:  f3_ctrl = ALU_SLL;
         3'b010:  f3_ctrl = ALU_SLT;
         3'b011:  f3_ctrl = ALU_SLTU;
         3'b100:  f3_ctrl = ALU_XOR;
         3'b101:  f3_ctrl = alt ? ALU_SRA : ALU_SRL;
         3'b110:  f3_ctrl = ALU_OR;
         default: f3_ctrl = ALU_AND;
      endcase
   endfunction
endpackage

// File: rtl/alu_issue_stage_if.sv
// ID->issue->EX handshake and operand bus for alu_issue_stage.
interface alu_issue_stage_if;
   import alu_pkg::*;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [3:0]      alu_control;
   logic [4:0]      rd_addr;
   logic            rd_we;
   logic [XLEN-1:0] out_pc;
   logic            illegal;

   modport slave (
      input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_control, rd_addr, rd_we, out_pc, illegal
   );
   modport master (
      output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_control, rd_addr, rd_we, out_pc, illegal
   );
endinterface

// File: rtl/alu_imm_gen.sv
// Combinational I-type / U-type immediate and shift-amount extraction.
module alu_imm_gen
   import alu_pkg::*;
(
   input  logic [31:12]     instr_hi_i,
   output logic [XLEN-1:0]  imm_i_o,
   output logic [XLEN-1:0]  imm_u_o,
   output logic [XLEN-1:0]  shamt_o
);
   assign imm_i_o = {{20{instr_hi_i[31]}}, instr_hi_i[31:20]};
   assign imm_u_o = {instr_hi_i[31:12], 12'b0};
   assign shamt_o = {27'b0, instr_hi_i[24:20]};
endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue register feeding the EX ALU, with valid/ready stall and flush.
// Define ALU_ILLEGAL_DET_EN to flag unsupported encodings on 'illegal'.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic              clk,
   input logic              rst_n,
   alu_issue_stage_if.slave bus
);
   logic [XLEN-1:0] imm_i, imm_u, shamt;
   logic [6:0]      opc, f7;
   logic [2:0]      f3;
   logic [4:0]      rd;
   logic            is_shift;

   logic [XLEN-1:0] a_d, b_d, a_q, b_q, pc_q;
   logic [3:0]      ctrl_d, ctrl_q;
   logic [4:0]      rd_q;
   logic            we_d, we_q, ill_d, ill_q, vld_q;

   alu_imm_gen u_imm (
      .instr_hi_i (bus.instr[31:12]),
      .imm_i_o    (imm_i),
      .imm_u_o    (imm_u),
      .shamt_o    (shamt)
   );

   assign opc      = bus.instr[6:0];
   assign rd       = bus.instr[11:7];
   assign f3       = bus.instr[14:12];
   assign f7       = bus.instr[31:25];
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

   // rs1 index bits are consumed by the register file upstream, not here.
   logic unused_bits;
   assign unused_bits = ^{bus.instr[19:15], f7};

   always_comb begin
      a_d    = '0;
      b_d    = '0;
      ctrl_d = ALU_ADD;
      we_d   = 1'b0;
      ill_d  = 1'b0;
      case (opc)
         OPC_OP: begin
            a_d    = bus.rs1_data;
            b_d    = bus.rs2_data;
            ctrl_d = f3_ctrl(f3, bus.instr[30] && (f3 == 3'b000 || f3 == 3'b101));
            we_d   = 1'b1;
`ifdef ALU_ILLEGAL_DET_EN
            ill_d  = (f7 != 7'b0000000) &&
                     !(f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
`endif
         end
         OPC_OPIMM: begin
            a_d    = bus.rs1_data;
            b_d    = is_shift ? shamt : imm_i;
            // instr[30] is immediate data except on the right shift
            ctrl_d = f3_ctrl(f3, bus.instr[30] && (f3 == 3'b101));
            we_d   = 1'b1;
`ifdef ALU_ILLEGAL_DET_EN
            ill_d  = is_shift && (f7 != 7'b0000000) &&
                     !(f3 == 3'b101 && f7 == 7'b0100000);
`endif
         end
         OPC_LUI: begin
            b_d  = imm_u;
            we_d = 1'b1;
         end
         OPC_AUIPC: begin
            a_d  = bus.pc;
            b_d  = imm_u;
            we_d = 1'b1;
         end
         default: begin
`ifdef ALU_ILLEGAL_DET_EN
            ill_d = 1'b1;
`endif
         end
      endcase
      we_d = we_d && (rd != 5'd0) && !ill_d;
   end

   assign bus.in_ready = !vld_q || bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         ctrl_q <= ALU_ADD;
         rd_q   <= '0;
         we_q   <= 1'b0;
         ill_q  <= 1'b0;
         pc_q   <= RESET_PC;
      end else if (bus.flush) begin
         vld_q  <= 1'b0;
      end else if (bus.in_valid && bus.in_ready) begin
         vld_q  <= 1'b1;
         a_q    <= a_d;
         b_q    <= b_d;
         ctrl_q <= ctrl_d;
         rd_q   <= rd;
         we_q   <= we_d;
         ill_q  <= ill_d;
         pc_q   <= bus.pc;
      end else if (bus.out_ready) begin
         vld_q  <= 1'b0;
      end
   end

   assign bus.out_valid   = vld_q;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;
   assign bus.alu_control = ctrl_q;
   assign bus.rd_addr     = rd_q;
   assign bus.rd_we       = we_q;
   assign bus.out_pc      = vld_q ? pc_q : RESET_PC;
`ifdef ALU_ILLEGAL_DET_EN
   assign bus.illegal     = ill_q;
`else
   assign bus.illegal     = 1'b0;
   logic unused_ill;
   assign unused_ill = ill_q;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed vector table plus stall/flush/reset sequences for alu_issue_stage.
module tb_alu_issue_stage;
   import alu_pkg::*;

`ifdef ALU_ILLEGAL_DET_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_issue_stage_if bus ();
   alu_issue_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      string       name;
      logic [31:0] instr, pc, rs1, rs2, a, b;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        we, ill;
   } vec_t;

   vec_t vecs[13];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2);
      bus.instr = ins; bus.pc = p; bus.rs1_data = r1; bus.rs2_data = r2;
   endtask

   initial begin
      vecs[0]  = '{"add",   32'h002081B3, 32'h0,   32'h5,        32'h7, 32'h5,        32'h7,        ALU_ADD,  5'd3,  1'b1, 1'b0};
      vecs[1]  = '{"srai",  32'h40435293, 32'h4,   32'h80000000, 32'h0, 32'h80000000, 32'h4,        ALU_SRA,  5'd5,  1'b1, 1'b0};
      vecs[2]  = '{"lui",   32'h123450B7, 32'h8,   32'h11,       32'h0, 32'h0,        32'h12345000, ALU_ADD,  5'd1,  1'b1, 1'b0};
      vecs[3]  = '{"auipc", 32'h00001117, 32'h100, 32'h11,       32'h0, 32'h100,      32'h1000,     ALU_ADD,  5'd2,  1'b1, 1'b0};
      vecs[4]  = '{"sub",   32'h40208233, 32'h10,  32'd20,       32'd3, 32'd20,       32'd3,        ALU_SUB,  5'd4,  1'b1, 1'b0};
      vecs[5]  = '{"sltiu", 32'hFFF0B313, 32'h14,  32'h9,        32'h0, 32'h9,        32'hFFFFFFFF, ALU_SLTU, 5'd6,  1'b1, 1'b0};
      vecs[6]  = '{"opc7f", 32'h000003FF, 32'h18,  32'h9,        32'h4, 32'h0,        32'h0,        ALU_ADD,  5'd7,  1'b0, ILL_EN};
      vecs[7]  = '{"add_x0",32'h00208033, 32'h1C,  32'h5,        32'h7, 32'h5,        32'h7,        ALU_ADD,  5'd0,  1'b0, 1'b0};
      vecs[8]  = '{"xori",  32'h0F00C413, 32'h20,  32'h3,        32'h0, 32'h3,        32'hF0,       ALU_XOR,  5'd8,  1'b1, 1'b0};
      vecs[9]  = '{"sll",   32'h002094B3, 32'h24,  32'h1,        32'h1F,32'h1,        32'h1F,       ALU_SLL,  5'd9,  1'b1, 1'b0};
      vecs[10] = '{"andi",  32'hFF00F513, 32'h28,  32'hABCD,     32'h0, 32'hABCD,     32'hFFFFFFF0, ALU_AND,  5'd10, 1'b1, 1'b0};
      vecs[11] = '{"mul",   32'h022081B3, 32'h2C,  32'h2,        32'h3, 32'h2,        32'h3,        ALU_ADD,  5'd3,  !ILL_EN, ILL_EN};
      vecs[12] = '{"sra",   32'h4020D1B3, 32'h30,  32'h80,       32'h2, 32'h80,       32'h2,        ALU_SRA,  5'd3,  1'b1, 1'b0};

      rst_n = 1'b0; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_pc",    bus.out_pc, 32'h0);
      chk("rst_a",     bus.alu_a, 0);
      chk("rst_we",    bus.rd_we, 0);
      chk("rst_ill",   bus.illegal, 0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
         bus.in_valid = 1'b1;
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk({vecs[i].name, "_vld"},  bus.out_valid, 1);
         chk({vecs[i].name, "_a"},    bus.alu_a, vecs[i].a);
         chk({vecs[i].name, "_b"},    bus.alu_b, vecs[i].b);
         chk({vecs[i].name, "_ctrl"}, bus.alu_control, vecs[i].ctrl);
         chk({vecs[i].name, "_rd"},   bus.rd_addr, vecs[i].rd);
         chk({vecs[i].name, "_we"},   bus.rd_we, vecs[i].we);
         chk({vecs[i].name, "_ill"},  bus.illegal, vecs[i].ill);
         chk({vecs[i].name, "_pc"},   bus.out_pc, vecs[i].pc);
         @(negedge clk);
         chk({vecs[i].name, "_drain"}, bus.out_valid, 0);
      end

      // Stall: second instruction waits three cycles, then issues back-to-back with the drain.
      drive(32'h002081B3, 32'h40, 32'd5, 32'd7);
      bus.in_valid = 1'b1;
      @(negedge clk);
      drive(32'h40208233, 32'h44, 32'd20, 32'd3);
      bus.out_ready = 1'b0;
      #1 chk("stall_in_ready", bus.in_ready, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall_vld", bus.out_valid, 1);
         chk("stall_a",   bus.alu_a, 32'd5);
         chk("stall_b",   bus.alu_b, 32'd7);
         chk("stall_ctl", bus.alu_control, ALU_ADD);
         chk("stall_pc",  bus.out_pc, 32'h40);
         chk("stall_rdy", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("unstall_vld", bus.out_valid, 1);
      chk("unstall_a",   bus.alu_a, 32'd20);
      chk("unstall_ctl", bus.alu_control, ALU_SUB);
      chk("unstall_rd",  bus.rd_addr, 5'd4);
      @(negedge clk);
      chk("unstall_drain", bus.out_valid, 0);

      // Flush kills both the registered and the incoming instruction.
      drive(32'h002081B3, 32'h50, 32'd5, 32'd7);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("pre_flush_vld", bus.out_valid, 1);
      drive(32'h40208233, 32'h54, 32'd20, 32'd3);
      bus.flush = 1'b1; bus.out_ready = 1'b0;
      @(negedge clk);
      chk("flush_vld", bus.out_valid, 0);
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      chk("post_flush_vld", bus.out_valid, 0);
      chk("post_flush_pc",  bus.out_pc, 32'h0);

      // Reset while stalled discards the held instruction.
      drive(32'h002081B3, 32'h60, 32'd5, 32'd7);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      @(negedge clk);
      chk("hold_vld", bus.out_valid, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_stall_vld", bus.out_valid, 0);
      chk("rst_stall_pc",  bus.out_pc, 32'h0);
      rst_n = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      chk("rst_stall_after", bus.out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
